fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/simple_cpu_pkg.sv | 14 +
 rtl/instruction_memory.sv | 29 ++
 rtl/fetch_controller.sv | 143 ++++++++++++++
 tb/tb_fetch_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
// Shared constants and fetch FSM state type for the simple CPU front end.
package simple_cpu_pkg;

    localparam int INSTR_W  = 12;
    localparam int IM_DEPTH = 8;
    localparam int IM_AW    = $clog2(IM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Small instruction store: synchronous write and clear, combinational read.
// Lives beside fetch_controller at the top level, driven by its im_* ports.
module instruction_memory
    import simple_cpu_pkg::*;
#(
    parameter int INSTR_W = simple_cpu_pkg::INSTR_W,
    parameter int AW      = simple_cpu_pkg::IM_AW
) (
    input  logic               i_clk,
    input  logic [AW-1:0]      i_index,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic               i_load,
    input  logic               i_reset,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
        end else if (i_load) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/fetch_controller.sv
// Program loader and sequential instruction fetcher with a valid/ready output.
// Define FETCH_JUMP_EN to enable jump_en/jump_target redirection; otherwise they are ignored.
module fetch_controller #(
    parameter int INSTR_W = simple_cpu_pkg::INSTR_W,
    parameter int AW      = simple_cpu_pkg::IM_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_valid,
    input  logic [INSTR_W-1:0] prog_instr,
    input  logic               prog_last,
    output logic               prog_ready,
    input  logic               start,
    input  logic               halt_req,
    input  logic               clear_req,
    input  logic               jump_en,
    input  logic [AW-1:0]      jump_target,
    output logic [AW-1:0]      im_index,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               im_load,
    output logic               im_reset,
    input  logic [INSTR_W-1:0] im_out,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [AW-1:0]      pc,
    output logic               loaded,
    output logic               done
);
    import simple_cpu_pkg::*;

    fetch_state_t       r_state, w_next;
    logic [AW:0]        r_pc;
    logic [AW:0]        r_prog_len;
    logic [AW-1:0]      r_wr_ptr;
    logic               r_loaded;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;

    logic w_idle, w_run;
    logic w_clear, w_accept, w_last_word, w_start;
    logic w_halt, w_jump, w_jump_oob, w_adv, w_fetch, w_end;
    logic [AW:0] w_jump_pc;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_run       = (r_state == ST_RUN);

    // clear beats a load word, and a load word beats start
    assign w_clear     = w_idle & clear_req;
    assign w_accept    = w_idle & ~clear_req & prog_valid;
    assign w_last_word = prog_last | (&r_wr_ptr);
    assign w_start     = w_idle & ~clear_req & ~prog_valid & start & r_loaded;

    assign w_halt      = w_run & halt_req;
`ifdef FETCH_JUMP_EN
    assign w_jump      = w_run & ~halt_req & jump_en;
    assign w_jump_pc   = {1'b0, jump_target};
`else
    logic w_jump_unused;
    assign w_jump_unused = jump_en ^ (^jump_target);
    assign w_jump      = 1'b0;
    assign w_jump_pc   = '0;
`endif
    assign w_jump_oob  = w_jump & (w_jump_pc >= r_prog_len);

    // output slot is free when empty or being consumed this cycle
    assign w_adv       = ~r_instr_valid | instr_ready;
    assign w_fetch     = w_run & ~halt_req & ~w_jump & w_adv & (r_pc < r_prog_len);
    assign w_end       = w_run & ~halt_req & ~w_jump & w_adv & (r_pc >= r_prog_len);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_RUN;
            ST_RUN:  if (w_halt || w_jump_oob || w_end) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        prog_ready = w_idle;
        im_load    = w_accept;
        im_index   = w_run ? r_pc[AW-1:0] : r_wr_ptr;
        im_wdata   = prog_instr;
        im_reset   = reset | w_clear;
        done       = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_prog_len    <= '0;
            r_wr_ptr      <= '0;
            r_loaded      <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_clear) begin
                r_loaded   <= 1'b0;
                r_prog_len <= '0;
                r_wr_ptr   <= '0;
            end else if (w_accept) begin
                if (w_last_word) begin
                    r_prog_len <= {1'b0, r_wr_ptr} + (AW+1)'(1);
                    r_loaded   <= 1'b1;
                    r_wr_ptr   <= '0;
                end else begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                end
            end

            if (w_start) begin
                r_pc          <= '0;
                r_instr_valid <= 1'b0;
            end

            if (w_halt || w_end) r_instr_valid <= 1'b0;

            if (w_jump) begin
                r_pc          <= w_jump_pc;
                r_instr_valid <= 1'b0;
            end

            if (w_fetch) begin
                r_instr       <= im_out;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + (AW+1)'(1);
            end
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc[AW-1:0];
    assign loaded      = r_loaded;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller + instruction_memory: directed scenarios plus
// randomized load/run/stall/halt checked against a program-list model.
module tb_fetch_controller;
    localparam int IW  = 12;
    localparam int AWL = 3;

    logic clk = 1'b0;
    logic reset, prog_valid, prog_last, prog_ready, start, halt_req, clear_req;
    logic jump_en, im_load, im_reset, instr_valid, instr_ready, loaded, done;
    logic [IW-1:0]  prog_instr, im_wdata, im_out, instr;
    logic [AWL-1:0] jump_target, im_index, pc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IW-1:0] prog [8];
    int            plen;
    logic [IW-1:0] got [$];

    fetch_controller #(.INSTR_W(IW), .AW(AWL)) dut (
        .clk(clk), .reset(reset),
        .prog_valid(prog_valid), .prog_instr(prog_instr), .prog_last(prog_last), .prog_ready(prog_ready),
        .start(start), .halt_req(halt_req), .clear_req(clear_req),
        .jump_en(jump_en), .jump_target(jump_target),
        .im_index(im_index), .im_wdata(im_wdata), .im_load(im_load), .im_reset(im_reset), .im_out(im_out),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .loaded(loaded), .done(done)
    );

    instruction_memory #(.INSTR_W(IW), .AW(AWL)) u_mem (
        .i_clk(clk), .i_index(im_index), .i_wdata(im_wdata),
        .i_load(im_load), .i_reset(im_reset), .o_rdata(im_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        prog_valid = 0; prog_instr = '0; prog_last = 0; start = 0; halt_req = 0;
        clear_req = 0; jump_en = 0; jump_target = '0; instr_ready = 0;
    endtask

    // writes prog[0..n-1]; model length is the first word flagged last or the 8th
    task automatic load_words(input int n, input bit use_last);
        plen = 0;
        for (int i = 0; i < n; i++) begin
            prog_valid = 1; prog_instr = prog[i]; prog_last = use_last && (i == n-1);
            #1;
            n_tests++;
            if (im_load !== 1'b1 || im_index !== AWL'(i) || im_wdata !== prog[i] || prog_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_write[%0d] load=%b idx=%0d data=%h want 1 %0d %h", i, im_load, im_index, im_wdata, i, prog[i]);
            end
            if (plen == 0 && (prog_last || i == 7)) plen = i + 1;
            tick;
        end
        prog_valid = 0; prog_last = 0;
        #1;
        n_tests++;
        if (loaded !== 1'b1) begin n_fail++; $display("FAIL load_loaded got %b want 1", loaded); end
    endtask

    task automatic run_prog(input int stall_pct, input int halt_after);
        bit fin = 0, held = 0, was_halt = 0, halting;
        logic [IW-1:0] hv = '0;
        got.delete();
        start = 1; tick; start = 0;
        #1;
        n_tests++;
        if (instr_valid !== 1'b0 || pc !== '0) begin n_fail++; $display("FAIL run_entry valid=%b pc=%0d want 0 0", instr_valid, pc); end
        for (int cyc = 0; cyc < 300; cyc++) begin
            halting = (halt_after >= 0) && (got.size() == halt_after);
            halt_req = halting;
            instr_ready = halting ? 1'b0 : ($urandom_range(99) >= stall_pct);
            #1;
            if (held && !was_halt) begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr !== hv) begin
                    n_fail++; $display("FAIL run_hold valid=%b instr=%h want 1 %h", instr_valid, instr, hv);
                end
            end
            if (done === 1'b1) begin fin = 1; break; end
            held = instr_valid && !instr_ready; hv = instr; was_halt = halting;
            if (instr_valid && instr_ready) got.push_back(instr);
            tick;
        end
        halt_req = 0; instr_ready = 0;
        n_tests++;
        if (!fin) begin n_fail++; $display("FAIL run_timeout got done=%b want 1", done); end
        tick;
        n_tests++;
        if (done !== 1'b0 || prog_ready !== 1'b1) begin n_fail++; $display("FAIL run_done_pulse done=%b ready=%b want 0 1", done, prog_ready); end
    endtask

    task automatic check_stream(input int exp_n);
        n_tests++;
        if (got.size() != exp_n) begin n_fail++; $display("FAIL stream_len got %0d want %0d", got.size(), exp_n); end
        for (int i = 0; i < got.size() && i < exp_n; i++) begin
            n_tests++;
            if (got[i] !== prog[i]) begin n_fail++; $display("FAIL stream[%0d] got %h want %h", i, got[i], prog[i]); end
        end
    endtask

    task automatic load_abc;
        prog[0] = 12'h101; prog[1] = 12'h202; prog[2] = 12'h303;
        load_words(3, 1);
    endtask

    task automatic test_reset;
        idle_inputs(); reset = 1;
        tick; tick;
        n_tests++;
        if (im_reset !== 1'b1 || instr_valid !== 1'b0 || done !== 1'b0 || loaded !== 1'b0 || pc !== '0 || instr !== '0 || prog_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_state imr=%b v=%b d=%b l=%b pc=%0d i=%h rdy=%b", im_reset, instr_valid, done, loaded, pc, instr, prog_ready);
        end
        reset = 0; tick;
        n_tests++;
        if (im_reset !== 1'b0) begin n_fail++; $display("FAIL reset_release im_reset=%b want 0", im_reset); end
    endtask

    task automatic test_basic_run;
        logic [IW-1:0] exp [3];
        exp[0] = 12'h101; exp[1] = 12'h202; exp[2] = 12'h303;
        load_abc();
        start = 1; tick; start = 0; instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== exp[i] || pc !== AWL'(i+1)) begin
                n_fail++; $display("FAIL basic_instr[%0d] v=%b instr=%h pc=%0d want 1 %h %0d", i, instr_valid, instr, pc, exp[i], i+1);
            end
        end
        tick;
        n_tests++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done done=%b v=%b want 1 0", done, instr_valid); end
        tick;
        n_tests++;
        if (done !== 1'b0 || prog_ready !== 1'b1 || loaded !== 1'b1) begin n_fail++; $display("FAIL basic_idle done=%b rdy=%b loaded=%b want 0 1 1", done, prog_ready, loaded); end
        instr_ready = 0;
        run_prog(0, -1);   // re-run of the retained program
        check_stream(3);
    endtask

    task automatic test_stall;
        start = 1; tick; start = 0; instr_ready = 1;
        tick; tick;
        instr_ready = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== 12'h202 || pc !== 3'd2) begin
                n_fail++; $display("FAIL stall_hold[%0d] v=%b instr=%h pc=%0d want 1 202 2", k, instr_valid, instr, pc);
            end
            tick;
        end
        instr_ready = 1;
        tick;
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== 12'h303 || pc !== 3'd3) begin n_fail++; $display("FAIL stall_next v=%b instr=%h pc=%0d want 1 303 3", instr_valid, instr, pc); end
        tick;
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done done=%b want 1", done); end
        instr_ready = 0; tick;
    endtask

    task automatic test_jump;
        start = 1; tick; start = 0; instr_ready = 1;
        tick; tick;
        jump_en = 1; jump_target = 3'd0;
        tick;
        jump_en = 0;
`ifdef FETCH_JUMP_EN
        n_tests++;
        if (instr_valid !== 1'b0 || pc !== 3'd0) begin n_fail++; $display("FAIL jump_redirect v=%b pc=%0d want 0 0", instr_valid, pc); end
        tick;
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== 12'h101) begin n_fail++; $display("FAIL jump_refetch v=%b instr=%h want 1 101", instr_valid, instr); end
        jump_en = 1; jump_target = 3'd5;
        tick;
        jump_en = 0;
        n_tests++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_oob done=%b v=%b want 1 0", done, instr_valid); end
`else
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== 12'h303 || pc !== 3'd3) begin n_fail++; $display("FAIL jump_ignored v=%b instr=%h pc=%0d want 1 303 3", instr_valid, instr, pc); end
        tick;
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL jump_ignored_done done=%b want 1", done); end
`endif
        instr_ready = 0; tick;
    endtask

    task automatic test_full_load;
        for (int i = 0; i < 8; i++) prog[i] = IW'($urandom);
        load_words(8, 0);
        n_tests++;
        if (plen != 8) begin n_fail++; $display("FAIL full_model_len got %0d want 8", plen); end
        run_prog(30, -1);
        check_stream(8);
        prog_valid = 1; prog_instr = 12'hABC; #1;
        n_tests++;
        if (im_load !== 1'b1 || im_index !== 3'd0) begin n_fail++; $display("FAIL ninth_word load=%b idx=%0d want 1 0", im_load, im_index); end
        tick; prog_valid = 0;
        clear_req = 1; tick; clear_req = 0;
    endtask

    task automatic test_clear;
        load_abc();
        clear_req = 1; prog_valid = 1; prog_instr = 12'h777; start = 1;
        #1;
        n_tests++;
        if (im_reset !== 1'b1 || im_load !== 1'b0) begin n_fail++; $display("FAIL clear_pulse imr=%b load=%b want 1 0", im_reset, im_load); end
        tick;
        clear_req = 0; prog_valid = 0; start = 0;
        #1;
        n_tests++;
        if (loaded !== 1'b0 || prog_ready !== 1'b1 || im_reset !== 1'b0) begin n_fail++; $display("FAIL clear_state loaded=%b rdy=%b imr=%b want 0 1 0", loaded, prog_ready, im_reset); end
        start = 1; tick; start = 0; tick;
        n_tests++;
        if (prog_ready !== 1'b1 || instr_valid !== 1'b0 || im_out !== '0) begin n_fail++; $display("FAIL clear_no_start rdy=%b v=%b mem0=%h want 1 0 000", prog_ready, instr_valid, im_out); end
    endtask

    task automatic test_reset_midrun;
        load_abc();
        start = 1; tick; start = 0; instr_ready = 1;
        tick; tick;
        reset = 1;
        #1;
        n_tests++;
        if (im_reset !== 1'b1) begin n_fail++; $display("FAIL midrun_imr got %b want 1", im_reset); end
        tick;
        n_tests++;
        if (instr_valid !== 1'b0 || instr !== '0 || pc !== '0 || done !== 1'b0 || loaded !== 1'b0 || prog_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrun_reset v=%b i=%h pc=%0d d=%b l=%b rdy=%b", instr_valid, instr, pc, done, loaded, prog_ready);
        end
        reset = 0; instr_ready = 0; tick;
    endtask

    task automatic test_random;
        int n, halt_after, exp_n;
        bit use_last;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 8);
            use_last = (n < 8) ? 1'b1 : 1'($urandom_range(1));
            for (int i = 0; i < 8; i++) prog[i] = IW'($urandom);
            load_words(n, use_last);
            halt_after = ($urandom_range(2) == 0) ? $urandom_range(0, n-1) : -1;
            run_prog($urandom_range(0, 60), halt_after);
            exp_n = (halt_after >= 0 && halt_after < plen) ? halt_after : plen;
            check_stream(exp_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_stall();
        test_jump();
        test_full_load();
        test_clear();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
